// File: rtl/led_channel_scheduler_pkg.sv
// Shared definitions for the LED channel scheduler: FSM state encoding and
// the latch-timer width helper.
package led_channel_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    ACTIVE = 2'd2,
    LATCH  = 2'd3
  } sched_state_e;

  // A zero-length latch gap still needs a legal (1-bit) timer vector.
  function automatic int timer_width(input int cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/led_channel_scheduler_one_hot_rr_pick.sv
// Combinational round-robin picker: returns the first set req bit at or above
// the one-hot ptr, wrapping from the MSB back to bit 0.
module led_channel_scheduler_one_hot_rr_pick #(
  parameter int NUM_CHANNELS = 5
) (
  input  logic [NUM_CHANNELS-1:0] req,
  input  logic [NUM_CHANNELS-1:0] ptr,
  output logic [NUM_CHANNELS-1:0] pick,
  output logic                    any
);

  logic [2*NUM_CHANNELS-1:0] dbl;
  logic [2*NUM_CHANNELS-1:0] diff;
  logic [2*NUM_CHANNELS-1:0] masked;

  // Subtracting ptr from the doubled request vector clears the first set bit
  // at or above ptr; a borrow running past the low copy models the wrap.
  always_comb begin
    dbl    = {req, req};
    diff   = dbl - {{NUM_CHANNELS{1'b0}}, ptr};
    masked = dbl & ~diff;
    pick   = masked[NUM_CHANNELS-1:0] | masked[2*NUM_CHANNELS-1:NUM_CHANNELS];
    any    = |req;
  end

endmodule

// File: rtl/led_channel_scheduler.sv
// Round-robin scheduler sharing one pixel serializer among LED strip outputs,
// with a latch gap enforced after every frame.
module led_channel_scheduler
  import led_channel_scheduler_pkg::*;
#(
  parameter  int NUM_CHANNELS = 5,
  parameter  int LATCH_CYCLES = 3000,
  localparam int IDX_W        = $clog2(NUM_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [NUM_CHANNELS-1:0] req,
  input  logic                    ser_done,
  output logic [NUM_CHANNELS-1:0] grant,
  output logic [IDX_W-1:0]        chan_idx,
  output logic                    ser_start,
  output logic                    busy,
  output logic                    latch
);

  localparam int TIMER_W = timer_width(LATCH_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST =
    TIMER_W'((LATCH_CYCLES > 0) ? (LATCH_CYCLES - 1) : 0);

  sched_state_e state, state_d;
  logic [NUM_CHANNELS-1:0] ptr, ptr_d;
  logic [NUM_CHANNELS-1:0] grant_d;
  logic [IDX_W-1:0]        idx_d;
  logic [TIMER_W-1:0]      timer, timer_d;
  logic                    start_d;

  logic [NUM_CHANNELS-1:0] pick;
  logic                    pick_any;
  logic [IDX_W-1:0]        pick_idx;

  led_channel_scheduler_one_hot_rr_pick #(
    .NUM_CHANNELS(NUM_CHANNELS)
  ) u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .any  (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (pick[i]) pick_idx = pick_idx | IDX_W'(i);
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    grant_d = grant;
    idx_d   = chan_idx;
    timer_d = timer;
    start_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && pick_any) begin
          grant_d = pick;
          idx_d   = pick_idx;
          state_d = START;
        end
      end
      START: begin
        start_d = 1'b1;
        state_d = ACTIVE;
      end
      ACTIVE: begin
        if (ser_done) begin
          ptr_d   = {grant[NUM_CHANNELS-2:0], grant[NUM_CHANNELS-1]};
          grant_d = '0;
          timer_d = '0;
          state_d = (LATCH_CYCLES == 0) ? IDLE : LATCH;
        end
      end
      LATCH: begin
        if (timer == TIMER_LAST) begin
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer + TIMER_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= NUM_CHANNELS'(1);
      grant     <= '0;
      chan_idx  <= '0;
      timer     <= '0;
      ser_start <= 1'b0;
      busy      <= 1'b0;
      latch     <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      grant     <= grant_d;
      chan_idx  <= idx_d;
      timer     <= timer_d;
      ser_start <= start_d;
      busy      <= (state_d != IDLE);
      latch     <= (state_d == LATCH);
    end
  end

endmodule

// File: tb/tb_led_channel_scheduler.sv
// Self-checking bench for led_channel_scheduler: directed scenarios plus
// randomized frames checked against a transaction-level round-robin model.
module tb_led_channel_scheduler;

  localparam int NCH = 5;
  localparam int LAT = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           enable = 1'b0;
  logic           ser_done = 1'b0;
  logic [NCH-1:0] req = '0;
  logic [NCH-1:0] grant;
  logic [2:0]     chan_idx;
  logic           ser_start;
  logic           busy;
  logic           latch;

  int checks = 0;
  int errors = 0;
  int ptr_m = 0;
  int last_idx = 0;

  led_channel_scheduler #(
    .NUM_CHANNELS(NCH),
    .LATCH_CYCLES(LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .req       (req),
    .ser_done  (ser_done),
    .grant     (grant),
    .chan_idx  (chan_idx),
    .ser_start (ser_start),
    .busy      (busy),
    .latch     (latch)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: first requesting channel at or after the priority index, with wrap.
  function automatic int rrPick(input int p, input logic [NCH-1:0] r);
    for (int i = 0; i < NCH; i++) begin
      if (r[(p + i) % NCH]) return (p + i) % NCH;
    end
    return -1;
  endfunction

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".grant"}, 32'(grant), 32'd0);
    checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
    checkOutput({tag, ".latch"}, 32'(latch), 32'd0);
    checkOutput({tag, ".ser_start"}, 32'(ser_start), 32'd0);
    checkOutput({tag, ".chan_idx"}, 32'(chan_idx), 32'(last_idx));
  endtask

  // Called at a negedge while the DUT is idle; returns at the idle cycle that follows.
  task automatic applyStimulus(input logic [NCH-1:0] r, input logic en, input int dly,
                               input logic scramble, input logic drop);
    int k;
    req    = r;
    enable = en;
    k = en ? rrPick(ptr_m, r) : -1;
    if (k < 0) begin
      ser_done = 1'b1;
      @(negedge clk);
      ser_done = 1'b0;
      checkIdle("idle");
    end else begin
      @(negedge clk);
      checkOutput("grant", 32'(grant), 32'(1 << k));
      checkOutput("chan_idx", 32'(chan_idx), 32'(k));
      checkOutput("busy", 32'(busy), 32'd1);
      checkOutput("start_early", 32'(ser_start), 32'd0);
      checkOutput("latch_early", 32'(latch), 32'd0);
      if (scramble) req = NCH'($urandom_range(0, 31));
      if (drop) enable = 1'b0;
      @(negedge clk);
      checkOutput("ser_start", 32'(ser_start), 32'd1);
      checkOutput("grant_start", 32'(grant), 32'(1 << k));
      for (int j = 0; j < dly; j++) begin
        @(negedge clk);
        checkOutput("start_pulse", 32'(ser_start), 32'd0);
        checkOutput("grant_hold", 32'(grant), 32'(1 << k));
        checkOutput("busy_active", 32'(busy), 32'd1);
      end
      ser_done = 1'b1;
      @(negedge clk);
      ser_done = 1'b0;
      for (int j = 0; j < LAT; j++) begin
        checkOutput("gap.latch", 32'(latch), 32'd1);
        checkOutput("gap.grant", 32'(grant), 32'd0);
        checkOutput("gap.busy", 32'(busy), 32'd1);
        checkOutput("gap.ser_start", 32'(ser_start), 32'd0);
        @(negedge clk);
      end
      ptr_m    = (k + 1) % NCH;
      last_idx = k;
      checkIdle("gap_end");
    end
  endtask

  task automatic resetInActive();
    req    = '1;
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst.grant", 32'(grant), 32'd0);
    checkOutput("arst.chan_idx", 32'(chan_idx), 32'd0);
    checkOutput("arst.ser_start", 32'(ser_start), 32'd0);
    checkOutput("arst.busy", 32'(busy), 32'd0);
    checkOutput("arst.latch", 32'(latch), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    ptr_m    = 0;
    last_idx = 0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst.grant", 32'(grant), 32'd0);
    checkOutput("rst.chan_idx", 32'(chan_idx), 32'd0);
    checkOutput("rst.ser_start", 32'(ser_start), 32'd0);
    checkOutput("rst.busy", 32'(busy), 32'd0);
    checkOutput("rst.latch", 32'(latch), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single requester and full rotation");
    applyStimulus(5'b00001, 1'b1, 3, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(5'b11111, 1'b1, 3, 1'b0, 1'b0);

    $display("[TB] enable drop mid-frame");
    applyStimulus(5'b11111, 1'b1, 3, 1'b0, 1'b1);
    applyStimulus(5'b11111, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(5'b11111, 1'b1, 3, 1'b0, 1'b0);

    $display("[TB] async reset in ACTIVE");
    resetInActive();
    applyStimulus(5'b11111, 1'b1, 3, 1'b0, 1'b0);
    applyStimulus(5'b00000, 1'b1, 0, 1'b0, 1'b0);

    $display("[TB] sparse requests");
    for (int i = 0; i < 3; i++) applyStimulus(5'b10010, 1'b1, 3, 1'b0, 1'b0);

    $display("[TB] randomized frames");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(NCH'($urandom_range(0, 31)), ($urandom_range(0, 7) != 0),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 5) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
